// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the memory-window dump engine.
package mem_dump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAP  = 2'd2,
        SEND = 2'd3
    } dump_state_e;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dump_trigger_timer.sv
// Free-running auto-trigger counter plus a saturating count of triggers
// that arrived while a dump was already in progress.
module dump_trigger_timer #(
    parameter int PERIOD = 0
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        busy,
    output logic        fire,
    output logic [15:0] overrun_count
);

    localparam int               CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST  = (PERIOD > 1) ? CNT_W'(PERIOD - 1) : '0;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      ovr_q, ovr_d;

    // Period counter and overrun register
    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q <= '0;
            ovr_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
        end
    end

    // Trigger decode, counter wrap and overrun saturation
    always_comb begin
        fire  = (PERIOD > 0) && (cnt_q == LAST);
        cnt_d = cnt_q;
        ovr_d = ovr_q;
        if (PERIOD == 0) begin
            cnt_d = '0;
        end else if (fire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (fire && busy && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end else begin
            ovr_d = ovr_q;
        end
    end

    assign overrun_count = ovr_q;

endmodule

// File: rtl/mem_window_dumper.sv
// Walks a ROWS x WORDS_PER_ROW window of data memory from a base address and
// streams each word over valid/ready, tagged with its row and column.
module mem_window_dumper
    import mem_dump_pkg::*;
#(
    parameter int          ADDR_W        = 32,
    parameter int          ROWS          = 3,
    parameter int          WORDS_PER_ROW = 8,
    parameter logic [31:0] ROW_STRIDE    = 32'h20,
    parameter int          PERIOD        = 0
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              base_addr,
    output logic                           mem_rd,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic [31:0]                    mem_rdata,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_data,
    output logic [ADDR_W-1:0]              out_addr,
    output logic [$clog2(ROWS):0]          out_row,
    output logic [$clog2(WORDS_PER_ROW):0] out_col,
    output logic                           out_eol,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done,
    output logic [15:0]                    dump_count,
    output logic [15:0]                    overrun_count
);

    localparam int                ROW_W      = $clog2(ROWS) + 1;
    localparam int                COL_W      = $clog2(WORDS_PER_ROW) + 1;
    localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(ROW_STRIDE);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

    dump_state_e       state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d, out_row_q, out_row_d;
    logic [COL_W-1:0]  col_q, col_d, out_col_q, out_col_d;
    logic [ADDR_W-1:0] base_q, base_d, row_addr_q, row_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, out_addr_q, out_addr_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [15:0]       dump_cnt_q, dump_cnt_d;
    logic              mem_rd_q, mem_rd_d, out_valid_q, out_valid_d;
    logic              out_eol_q, out_eol_d, out_last_q, out_last_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              fire_s, last_col_s, last_row_s;

    dump_trigger_timer #(
        .PERIOD(PERIOD)
    ) u_timer (
        .CLK          (CLK),
        .reset        (reset),
        .busy         (busy_q),
        .fire         (fire_s),
        .overrun_count(overrun_count)
    );

    // State and output registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            base_q      <= '0;
            row_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0000_0000;
            out_addr_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_eol_q   <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dump_cnt_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            base_q      <= base_d;
            row_addr_q  <= row_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_eol_q   <= out_eol_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dump_cnt_q  <= dump_cnt_d;
        end
    end

    // Next-state logic; addresses advance incrementally instead of multiplying
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        base_d      = base_q;
        row_addr_d  = row_addr_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_eol_d   = out_eol_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dump_cnt_d  = dump_cnt_q;
        last_col_s  = (col_q == COL_W'(WORDS_PER_ROW - 1));
        last_row_s  = (row_q == ROW_W'(ROWS - 1));
        case (state_q)
            IDLE: begin
                if (start || fire_s) begin
                    base_d     = start ? (base_addr & ALIGN_MASK) : base_q;
                    row_addr_d = base_d;
                    mem_addr_d = base_d;
                    row_d      = '0;
                    col_d      = '0;
                    busy_d     = 1'b1;
                    mem_rd_d   = 1'b1;
                    state_d    = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                state_d = CAP;
            end
            CAP: begin
                out_data_d  = mem_rdata;
                out_addr_d  = mem_addr_q;
                out_row_d   = row_q;
                out_col_d   = col_q;
                out_eol_d   = last_col_s;
                out_last_d  = last_col_s && last_row_s;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        dump_cnt_d = dump_cnt_q + 16'd1;
                        state_d    = IDLE;
                    end else begin
                        mem_rd_d = 1'b1;
                        state_d  = REQ;
                        if (out_eol_q) begin
                            col_d      = '0;
                            row_d      = row_q + ROW_W'(1);
                            row_addr_d = row_addr_q + STRIDE;
                            mem_addr_d = row_addr_d;
                        end else begin
                            col_d      = col_q + COL_W'(1);
                            mem_addr_d = mem_addr_q + ADDR_W'(WORD_BYTES);
                        end
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_addr   = out_addr_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign out_eol    = out_eol_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dump_count = dump_cnt_q;

endmodule

// File: tb/tb_mem_window_dumper.sv
// Directed bench: default-geometry dumper plus a small auto-triggered instance.
module tb_mem_window_dumper;

    logic        CLK = 1'b0;
    logic        reset = 1'b1, start = 1'b0, out_ready = 1'b1;
    logic [31:0] base_addr = 32'h0, mem_rdata = 32'h0;
    logic        mem_rd, out_valid, out_eol, out_last, busy, done;
    logic [31:0] mem_addr, out_data, out_addr;
    logic [2:0]  out_row;
    logic [3:0]  out_col;
    logic [15:0] dump_count, overrun_count;

    logic        reset_b = 1'b1, start_b = 1'b0, ready_b = 1'b0;
    logic [31:0] base_b = 32'h0, rdata_b = 32'h0;
    logic        rd_b, valid_b, eol_b, last_b, busy_b, done_b;
    logic [31:0] addr_b, data_b, oaddr_b;
    logic [0:0]  row_b;
    logic [1:0]  col_b;
    logic [15:0] dcnt_b, ovr_b;

    int n_chk = 0, n_pass = 0;
    int n_words, done_cyc;
    logic [31:0] rec_addr[64], rec_data[64];
    logic [2:0]  rec_row[64];
    logic [3:0]  rec_col[64];
    logic        rec_eol[64], rec_last[64];

    always #5 CLK = ~CLK;

    mem_window_dumper u_dut (
        .CLK(CLK), .reset(reset), .start(start), .base_addr(base_addr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_row(out_row), .out_col(out_col),
        .out_eol(out_eol), .out_last(out_last), .busy(busy), .done(done),
        .dump_count(dump_count), .overrun_count(overrun_count)
    );

    mem_window_dumper #(.ROWS(1), .WORDS_PER_ROW(2), .PERIOD(40)) u_dut_per (
        .CLK(CLK), .reset(reset_b), .start(start_b), .base_addr(base_b),
        .mem_rd(rd_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
        .out_addr(oaddr_b), .out_row(row_b), .out_col(col_b),
        .out_eol(eol_b), .out_last(last_b), .busy(busy_b), .done(done_b),
        .dump_count(dcnt_b), .overrun_count(ovr_b)
    );

    // Little-endian byte memory: a few fixed bytes, the rest derived from the address
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h1001_0018: return 8'h11;
            32'h1001_0019: return 8'h22;
            32'h1001_001A: return 8'h33;
            32'h1001_001B: return 8'h44;
            default:       return a[7:0] ^ 8'hA5 ^ a[23:16];
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    always @(posedge CLK) if (mem_rd) mem_rdata <= mem_word(mem_addr);
    always @(posedge CLK) if (rd_b) rdata_b <= mem_word(addr_b);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Start a dump on the main instance and record every accepted word
    task automatic run_dump(input logic [31:0] base, input int mode, input int poke);
        int cyc;
        int dones;
        logic stall_prev;
        logic [31:0] held_data, held_addr;
        n_words = 0; dones = 0; done_cyc = -1; stall_prev = 1'b0;
        held_data = 32'h0; held_addr = 32'h0;
        @(negedge CLK); start = 1'b1; base_addr = base; out_ready = 1'b1;
        @(negedge CLK); start = 1'b0;
        check("first_mem_rd", mem_rd, 1);
        check("first_mem_addr", mem_addr, base & 32'hFFFF_FFFC);
        check("first_busy", busy, 1);
        check("first_valid", out_valid, 0);
        cyc = 1;
        while (cyc < 600 && dones == 0) begin
            out_ready = (mode == 1) ? (cyc % 4 == 3) : 1'b1;
            if (cyc == poke) begin start = 1'b1; base_addr = 32'h2000_0000; end
            else start = 1'b0;
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, held_data);
                check("stall_addr", out_addr, held_addr);
            end
            if (out_valid && out_ready && n_words < 64) begin
                rec_addr[n_words] = out_addr; rec_data[n_words] = out_data;
                rec_row[n_words] = out_row; rec_col[n_words] = out_col;
                rec_eol[n_words] = out_eol; rec_last[n_words] = out_last;
                n_words++;
            end
            stall_prev = out_valid && !out_ready;
            held_data = out_data; held_addr = out_addr;
            if (done) begin dones++; done_cyc = cyc; end
            else begin @(negedge CLK); cyc++; end
        end
        start = 1'b0; out_ready = 1'b1;
        check("done_seen", dones, 1);
        check("done_busy_low", busy, 0);
        @(negedge CLK);
        check("done_one_cycle", done, 0);
    endtask

    task automatic verify_seq(input logic [31:0] base);
        logic [31:0] ea;
        check("word_count", n_words, 24);
        for (int k = 0; k < 24; k++) begin
            ea = base + 32'(k / 8) * 32'h20 + 32'(k % 8) * 32'd4;
            check("seq_addr", rec_addr[k], ea);
            check("seq_data", rec_data[k], mem_word(ea));
            check("seq_row", rec_row[k], k / 8);
            check("seq_col", rec_col[k], k % 8);
            check("seq_eol", rec_eol[k], (k % 8) == 7);
            check("seq_last", rec_last[k], k == 23);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (3) @(negedge CLK);
        check("rst_mem_rd", mem_rd, 0);      check("rst_mem_addr", mem_addr, 0);
        check("rst_valid", out_valid, 0);    check("rst_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);  check("rst_row", out_row, 0);
        check("rst_col", out_col, 0);        check("rst_eol", out_eol, 0);
        check("rst_last", out_last, 0);      check("rst_busy", busy, 0);
        check("rst_done", done, 0);          check("rst_dump_count", dump_count, 0);
        check("rst_overrun", overrun_count, 0);
        reset = 1'b0;

        // Reset while a word is waiting in SEND
        @(negedge CLK); start = 1'b1; base_addr = 32'h1001_0000; out_ready = 1'b0;
        @(negedge CLK); start = 1'b0;
        w = 0;
        while (!out_valid && w < 10) begin @(negedge CLK); w++; end
        check("midsend_valid", out_valid, 1);
        @(negedge CLK); reset = 1'b1;
        @(negedge CLK); reset = 1'b0; out_ready = 1'b1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_dump_count", dump_count, 0);
        @(negedge CLK);
        check("midrst_no_done", done, 0);

        // Full dump, ready held high, misaligned base bits ignored
        run_dump(32'h1001_0002, 0, -1);
        verify_seq(32'h1001_0000);
        check("dump_cycles", done_cyc, 73);
        check("dump_count_1", dump_count, 1);
        check("byte_order_18", rec_data[6], 32'hA3A2A1A0 ^ 32'hA3A2A1A0 ^ 32'h44332211);
        check("byte_order_04", rec_data[1], 32'hA3A2A1A0);

        // Back-pressure with an ignored start while busy
        run_dump(32'h1001_0000, 1, 10);
        verify_seq(32'h1001_0000);
        check("dump_count_2", dump_count, 2);

        // Address wrap at 2^32
        run_dump(32'hFFFF_FFF0, 0, -1);
        verify_seq(32'hFFFF_FFF0);
        check("wrap_idx3", rec_addr[3], 32'hFFFF_FFFC);
        check("wrap_idx4", rec_addr[4], 32'h0000_0000);
        check("wrap_idx7", rec_addr[7], 32'h0000_000C);
        check("wrap_idx8", rec_addr[8], 32'h0000_0010);
        check("wrap_idx23", rec_addr[23], 32'h0000_004C);
        check("dump_count_3", dump_count, 3);
        check("no_auto_overrun", overrun_count, 0);

        // Periodic instance: first trigger at edge 40, blocked triggers at 80 and 120
        @(negedge CLK); reset_b = 1'b0; ready_b = 1'b0;
        for (int i = 1; i <= 130; i++) begin
            @(negedge CLK);
            start_b = (i == 60);
            base_b = (i == 60) ? 32'h0000_1234 : 32'h0;
            if (i == 39) check("per_idle_before", busy_b, 0);
            if (i == 60) begin
                check("per_busy", busy_b, 1);
                check("per_ovr_0", ovr_b, 0);
            end
        end
        start_b = 1'b0;
        check("per_ovr_2", ovr_b, 2);
        check("per_valid", valid_b, 1);
        check("per_addr", oaddr_b, 0);
        check("per_dcnt_0", dcnt_b, 0);
        ready_b = 1'b1;
        w = 0;
        while (!done_b && w < 20) begin @(negedge CLK); w++; end
        check("per_done", done_b, 1);
        check("per_dcnt_1", dcnt_b, 1);
        w = 0;
        while (!rd_b && w < 60) begin @(negedge CLK); w++; end
        check("per_retrigger", rd_b, 1);
        check("per_base_kept", addr_b, 0);
        check("per_ovr_kept", ovr_b, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_window_dumper.md
# mem_window_dumper

Synthesizable, parametrised memory-window dump engine for the single-cycle MIPS core's data memory. On a start pulse or periodic trigger, it walks a rectangular window of ROWS × WORDS_PER_ROW 32-bit words from a base address. Each word is read through a one-cycle-latency read port and streamed out over a valid/ready interface tagged with row and word position. It replaces fixed per-tick memory printouts with a reusable block that a monitor, UART, or bench sink can consume.

## Interface
- ADDR_W, 32, address width of the data-memory read port
- ROWS, 3, rows per dump (≥1)
- WORDS_PER_ROW, 8, 32-bit words per row (≥1)
- ROW_STRIDE, 32'h20, byte distance between row start addresses
- PERIOD, 0, auto-trigger period in cycles; 0 disables auto-trigger
- CLK  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a dump; ignored while busy
- base_addr  in  ADDR_W  window base; sampled on accepted start; bits [1:0] forced to 0
- mem_rd  out  1  read strobe to data memory
- mem_addr  out  ADDR_W  word-aligned byte address of read
- mem_rdata  in  32  little-endian word: byte addr+3 in [31:24], addr+0 in [7:0]; valid cycle after mem_rd
- out_valid  out  1  out_data/tags valid
- out_ready  in  1  sink accepts when out_valid && out_ready
- out_data  out  32  word read
- out_addr  out  ADDR_W  byte address of out_data
- out_row  out  $clog2(ROWS)+1  row index, 0-based
- out_col  out  $clog2(WORDS_PER_ROW)+1  word index within row, 0-based
- out_eol  out  1  last word of row
- out_last  out  1  last word of dump
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse after last word accepted
- dump_count  out  16  completed dumps, wraps at 16'hFFFF→0
- overrun_count  out  16  auto-triggers dropped because busy, saturates at 16'hFFFF

## Operation
- FSM states: IDLE, REQ, CAP, SEND.
- IDLE: on trigger (start, or auto-trigger), latch the base, clear row/col, set busy, go to REQ. If start and auto-trigger coincide, one dump runs, using base_addr.
- Auto-trigger uses a free-running counter 0..PERIOD-1. The trigger fires at PERIOD-1 and uses the last latched base (reset value 0).
- REQ: mem_rd=1, mem_addr = base + row*ROW_STRIDE + col*4 (mod 2^ADDR_W) → CAP.
- CAP: register mem_rdata into out_data along with the tags → SEND.
- SEND: out_valid=1; outputs are held stable until the handshake. On handshake:
  - If last word: clear busy, pulse done, increment dump_count → IDLE.
  - Otherwise: advance col; at col wrap, reset col and increment row → REQ.
- Address arithmetic wraps silently at 2^ADDR_W. There is no error on wrap.
- Start while busy is ignored (not counted). An auto-trigger while busy increments overrun_count.
- Reset in any state → IDLE. No partial dump completes, and no done pulse is generated.

## Timing
- Reset values: mem_rd 0, mem_addr 0, out_valid 0, out_data 0, out_addr 0, out_row 0, out_col 0, out_eol 0, out_last 0, busy 0, done 0, dump_count 0, overrun_count 0.
- Start accepted at edge N → mem_rd high in cycle N+1 → out_valid high from cycle N+3.
- Each word takes 3 cycles minimum with out_ready held high. A full dump takes 3·ROWS·WORDS_PER_ROW cycles from the first REQ.
- Back-pressure: out_valid stays high and all out_* stay constant until out_ready. A valid word is never dropped.
- done is asserted in the cycle after the final handshake, coincident with busy=0. A new start may be accepted in that same cycle.
- mem_rd is high only in REQ, for exactly one cycle per word.

## Structure
- Shared package mem_dump_pkg holds the state enum (IDLE/REQ/CAP/SEND) and the WORD_BYTES=4 constant.
- Optional sub-module dump_trigger_timer contains the PERIOD counter and the overrun saturation logic. Everything else lives in one module.

## Test plan
- Defaults, base 32'h1001_0000, out_ready=1 → 24 words; addresses 1001_0000..1001_005C in order; out_eol on col 7; out_last only on row 2 col 7; done once; dump_count=1.
- Memory byte 1001_0018..1B = 11,22,33,44 → word at 1001_0018 reads 32'h44332211. Word at 1001_0004 uses bytes +7..+4, with no byte duplication.
- out_ready toggled 1-in-4 → identical sequence, and out_data stable while out_valid && !out_ready.
- base 32'hFFFF_FFF0, ROWS=1, WORDS_PER_ROW=8 → addresses FFFF_FFF0..FFFF_FFFC, then 0000_0000..0000_000C.
- PERIOD=40 with out_ready=0 for 100 cycles → overrun_count increments per blocked trigger; start pulses while busy ignored.
- Reset asserted mid-SEND → next cycle out_valid=0, busy=0, dump_count unchanged; a fresh start then completes normally.
